wash_phase_timer: RTL

Phase timer and pass scheduler for the washing-machine controller FSM. The block watches the FSM's 3-bit `state` and loads a per-phase duration on every phase entry. It counts that duration down in minute ticks from a clock prescaler and returns a one-cycle `state_done` pulse that the FSM uses to advance. It also latches the double-wash request, tracks the first/second wash pass, freezes the spin phase on `timer_pause`, and flags illegal state codes.

---
 rtl/wash_phase_timer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wash_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : wash_phase_timer
// Description : Phase timer and pass scheduler for the washing-machine
//               controller FSM. Loads a per-phase duration on every phase
//               entry, counts it down in minute ticks from a clock prescaler
//               and returns a one-cycle state_done pulse. It also latches the
//               double-wash request, tracks the first/second wash pass,
//               freezes the SPIN phase on timer_pause and flags illegal
//               state codes.
// Ports       :
//   clk          in  system clock, rising edge
//   rst_n        in  asynchronous active-low reset
//   state        in  FSM phase (0 IDLE,1 FILL,2 WASH,3 RINSE,4 SPIN, 5-7 bad)
//   double_wash  in  double-wash request, sampled on IDLE->FILL entry only
//   timer_pause  in  pause request, honoured only in SPIN
//   state_done   out one-cycle pulse at the end of the phase duration
//   time_left    out minutes remaining in the current phase
//   second_pass  out high while the second wash/rinse pass is due/running
//   phase_err    out high while state holds an illegal code
// Revision    : 1.0 - initial release
// ============================================================================
module wash_phase_timer #(
  parameter int TICK_CYCLES = 60,
  parameter int CNT_W       = 8,
  parameter int FILL_MIN    = 2,
  parameter int WASH_MIN    = 5,
  parameter int RINSE_MIN   = 2,
  parameter int SPIN_MIN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       state,
  input  logic             double_wash,
  input  logic             timer_pause,
  output logic             state_done,
  output logic [CNT_W-1:0] time_left,
  output logic             second_pass,
  output logic             phase_err
);

  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_CNT_ONE    = CNT_W'(1);

  localparam logic [2:0] C_ST_IDLE  = 3'd0;
  localparam logic [2:0] C_ST_FILL  = 3'd1;
  localparam logic [2:0] C_ST_WASH  = 3'd2;
  localparam logic [2:0] C_ST_RINSE = 3'd3;
  localparam logic [2:0] C_ST_SPIN  = 3'd4;

  logic [2:0]         r_prev_state;
  logic [PRESC_W-1:0] r_presc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dw_lat;

  logic               w_entry;
  logic               w_legal;
  logic               w_paused;
  logic               w_counting;
  logic               w_tick;
  logic               w_done;
  logic [CNT_W-1:0]   w_load;

  // Entry edge: the sampled phase differs from the one we last loaded for.
  assign w_entry  = (state != r_prev_state);
  assign w_legal  = (state <= C_ST_SPIN);
  assign w_paused = (state == C_ST_SPIN) && timer_pause;

  // Counting is suppressed on an entry edge so the reload always wins over a
  // coinciding tick; a pause freezes the prescaler and therefore any pending
  // done, deferring the pulse until resume.
  assign w_counting = !w_entry && w_legal && (state != C_ST_IDLE) &&
                      (r_cnt != '0) && !w_paused;
  assign w_tick     = w_counting && (r_presc == C_PRESC_LAST);
  assign w_done     = w_tick && (r_cnt == C_CNT_ONE);

  // Duration loaded on entry; IDLE and illegal codes load zero so they never
  // count and never pulse.
  always_comb begin
    w_load = '0;
    case (state)
      C_ST_FILL:  w_load = CNT_W'(FILL_MIN);
      C_ST_WASH:  w_load = CNT_W'(WASH_MIN);
      C_ST_RINSE: w_load = CNT_W'(RINSE_MIN);
      C_ST_SPIN:  w_load = CNT_W'(SPIN_MIN);
      default:    w_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_state <= C_ST_IDLE;
      r_presc      <= '0;
      r_cnt        <= '0;
      r_dw_lat     <= 1'b0;
      second_pass  <= 1'b0;
      state_done   <= 1'b0;
      phase_err    <= 1'b0;
    end else begin
      phase_err  <= !w_legal;
      state_done <= w_done;

      if (w_entry) begin
        r_prev_state <= state;
        r_presc      <= '0;
        r_cnt        <= w_load;
        if ((r_prev_state == C_ST_IDLE) && (state == C_ST_FILL)) begin
          r_dw_lat <= double_wash;
        end
        if (state == C_ST_IDLE) begin
          second_pass <= 1'b0;
        end
      end else if (w_counting) begin
        if (w_tick) begin
          r_presc <= '0;
          r_cnt   <= r_cnt - C_CNT_ONE;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end

      // w_done can only be true off an entry edge, so this never races the
      // IDLE-entry clear above.
      if (w_done && (state == C_ST_RINSE) && r_dw_lat) begin
        second_pass <= 1'b1;
      end
    end
  end

  assign time_left = r_cnt;

endmodule
`default_nettype wire
